instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  64  byte address of the requested word.
REQ-006 SHALL have port imem_ack  input  1  memory response valid, one cycle per request.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port instr_valid  output  1  instruction/pc valid toward the decode/control stage.
REQ-009 SHALL have port instr_ready  input  1  decode stage accepts instruction this cycle.
REQ-010 SHALL have port instruction  output  32  fetched instruction word.
REQ-011 SHALL have port pc  output  64  address of the presented instruction.
REQ-012 SHALL have port redirect  input  1  taken-branch redirect request.
REQ-013 SHALL have port redirect_pc  input  64  new fetch address, sampled when redirect=1.
REQ-014 SHALL have port halt  output  1  sticky; fetched word was 32'h00000000.
REQ-015 SHALL have port fault  output  1  sticky; redirect_pc[1:0] != 2'b00.
REQ-016 SHALL have port fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-017 SHALL implement states IDLE, REQ, VALID, HALT, FAULT; reset state IDLE.
REQ-018 IDLE SHALL move to REQ on the first clock edge after rst_n deasserts.
REQ-019 REQ SHALL drive imem_req=1 and imem_addr=fetch_pc, holding both stable until imem_ack.
REQ-020 On imem_ack in REQ with no pending discard, SHALL latch imem_rdata into instruction, set pc=fetch_pc, and go to VALID.
REQ-021 VALID SHALL drive instr_valid=1 and imem_req=0; instruction and pc SHALL be held constant while instr_ready=0.
REQ-022 VALID with instr_ready=1 and redirect=0 SHALL set fetch_pc=fetch_pc+4 (64-bit, wraps modulo 2^64), increment fetch_count (wraps modulo 2^32), and go to REQ; minimum throughput is one instruction per 2 cycles plus memory latency.
REQ-023 Redirect in VALID SHALL take priority over instr_ready: the instruction is dropped, fetch_count is not incremented, fetch_pc=redirect_pc, next state REQ.
REQ-024 Redirect in REQ SHALL set a discard flag and fetch_pc=redirect_pc; the outstanding request is not cancelled; imem_addr keeps the old address until imem_ack.
REQ-025 With the discard flag set, imem_ack SHALL drop imem_rdata, clear the flag, and stay in REQ to issue a new request at fetch_pc the following cycle.
REQ-026 Redirect in the same cycle as imem_ack in REQ SHALL discard that response and re-request at redirect_pc.
REQ-027 A later redirect SHALL overwrite fetch_pc; the last redirect before the new request wins.
REQ-028 A redirect with redirect_pc[1:0]!=0 SHALL go to FAULT regardless of state (except HALT) and assert fault=1.
REQ-029 A non-discarded response of 32'h00000000 SHALL go to HALT with halt=1 and instr_valid=0.
REQ-030 HALT and FAULT SHALL be absorbing until reset: imem_req=0, instr_valid=0, redirect ignored.
REQ-031 In the absence of redirect, instr_valid SHALL never be retracted before instr_ready.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instruction=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, halt=0, fault=0, fetch_count=0, discard flag=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; a subsequent imem_ack SHALL be ignored until state REQ is re-entered.

Verification
REQ-034 Reset release, memory acks 1 cycle after req with 0x00500093 -> imem_addr=0, instr_valid=1 with pc=0, instruction=0x00500093; after instr_ready, next imem_addr=4 and fetch_count=1.
REQ-035 Hold instr_ready=0 for 5 cycles in VALID -> instruction/pc stable, imem_req=0, fetch_count unchanged.
REQ-036 Redirect to 0x40 while request to 0x8 is outstanding, ack 3 cycles later -> response dropped, next imem_addr=0x40, instr_valid stays 0 until the 0x40 word returns.
REQ-037 Redirect to 0x80 with instr_ready=1 in VALID -> fetch_count unchanged, next imem_addr=0x80.
REQ-038 Memory returns 0x00000000 at pc=0xC -> halt=1, instr_valid=0, imem_req=0 thereafter; redirect ignored.
REQ-039 Redirect to 0x42 -> fault=1, imem_req=0; assert rst_n=0 -> fault=0, fetch_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory read channel, decode handshake,
// redirect input and status outputs.
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc, halt, fault, fetch_count,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc, halt, fault, fetch_count,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at a time,
// presents it to decode, and follows redirects, halting on an all-zero word.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, HALT, FAULT} state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        discard_q, discard_d;
  logic        halt_q, halt_d;
  logic        fault_q, fault_d;
  logic        redirect_bad;

  assign redirect_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
      fault_q    <= fault_d;
    end
  end

  // addr_q is the address of the request on the bus; fetch_pc_q may run ahead
  // of it while a redirected request is still waiting for its ack.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          addr_d     = bus.redirect_pc;
          state_d    = REQ;
        end else begin
          addr_d  = fetch_pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (bus.imem_ack) begin
          if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            addr_d     = bus.redirect_pc;
            discard_d  = 1'b0;
          end else if (discard_q) begin
            addr_d    = fetch_pc_q;
            discard_d = 1'b0;
          end else if (bus.imem_rdata == 32'h0) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else begin
            instr_d = bus.imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = VALID;
          end
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          discard_d  = 1'b1;
        end
      end
      VALID: begin
        if (redirect_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          addr_d     = bus.redirect_pc;
          state_d    = REQ;
        end else if (bus.instr_ready) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          addr_d     = fetch_pc_q + 64'd4;
          count_d    = count_q + 32'd1;
          state_d    = REQ;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == REQ);
    bus.instr_valid = (state_q == VALID);
    bus.imem_addr   = addr_q;
    bus.instruction = instr_q;
    bus.pc          = pc_q;
    bus.halt        = halt_q;
    bus.fault       = fault_q;
    bus.fetch_count = count_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch, stall, redirect, halt and
// fault scenarios against a small latency-programmable memory model.
module tb_instr_fetch;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } out_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   lat;
  out_t        exp_out[$];
  logic [63:0] exp_req[$];

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    case (a)
      64'h00: word_at = 32'h00500093;
      64'h04: word_at = 32'h00100113;
      64'h08: word_at = 32'h00208193;
      64'h0C: word_at = 32'h00000000;
      64'h40: word_at = 32'h00300213;
      64'h44: word_at = 32'h00400293;
      64'h80: word_at = 32'h00500313;
      64'h84: word_at = 32'h00000000;
      default: word_at = 32'h00000013;
    endcase
  endfunction

  // Memory model: latches a request, acks lat cycles later for one cycle,
  // and checks each issued address against the expected request queue.
  initial begin
    logic        busy;
    int          cnt;
    logic [63:0] maddr;
    busy = 1'b0;
    cnt = 0;
    maddr = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        busy = 1'b0;
      end else begin
        if (bus.imem_ack) begin
          bus.imem_ack = 1'b0;
          busy = 1'b0;
        end else if (busy) begin
          if (cnt == 0) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = word_at(maddr);
          end else begin
            cnt--;
          end
        end
        if (!busy && bus.imem_req) begin
          maddr = bus.imem_addr;
          busy = 1'b1;
          cnt = lat - 1;
          if (exp_req.size() == 0) check("unexpected_req", maddr, 64'hFFFF_FFFF_FFFF_FFFF);
          else check("req_addr", maddr, exp_req.pop_front());
        end
      end
    end
  end

  // Output monitor: every accepted instruction is matched against the queue.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (exp_out.size() == 0) begin
          check("unexpected_instr_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_out.pop_front();
          check("out_pc", bus.pc, e.pc);
          check("out_instr", {32'h0, bus.instruction}, {32'h0, e.ins});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    #1;
    check("rst_req", {63'h0, bus.imem_req}, 64'h0);
    check("rst_addr", bus.imem_addr, 64'h0);
    check("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("rst_pc", bus.pc, 64'h0);
    check("rst_instr", {32'h0, bus.instruction}, 64'h0);
    check("rst_halt", {63'h0, bus.halt}, 64'h0);
    check("rst_fault", {63'h0, bus.fault}, 64'h0);
    check("rst_count", {32'h0, bus.fetch_count}, 64'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic redirect_pulse(input logic [63:0] target);
    @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = target;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_req_left"}, exp_req.size(), 0);
    check({tag, "_out_left"}, exp_out.size(), 0);
  endtask

  initial begin
    logic        seen;
    logic [63:0] pc0;
    logic [31:0] ins0;
    total = 0;
    bad = 0;
    lat = 1;
    rst_n = 1'b0;

    // Basic fetch, decode stall, sequential fetch, halt on zero word.
    exp_req = '{64'h0, 64'h4, 64'h8, 64'hC};
    exp_out.push_back('{64'h0, 32'h00500093});
    exp_out.push_back('{64'h4, 32'h00100113});
    exp_out.push_back('{64'h8, 32'h00208193});
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.instr_valid;
    end
    check("t1_first_valid_timeout", {63'h0, seen}, 64'h1);
    pc0 = bus.pc;
    ins0 = bus.instruction;
    check("t1_first_pc", pc0, 64'h0);
    check("t1_first_instr", {32'h0, ins0}, 64'h00500093);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_stall_pc", bus.pc, 64'h0);
      check("t1_stall_instr", {32'h0, bus.instruction}, 64'h00500093);
      check("t1_stall_req", {63'h0, bus.imem_req}, 64'h0);
      check("t1_stall_valid", {63'h0, bus.instr_valid}, 64'h1);
      check("t1_stall_count", {32'h0, bus.fetch_count}, 64'h0);
    end
    @(posedge clk);
    #1 bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t1_count_after_accept", {32'h0, bus.fetch_count}, 64'h1);
    check("t1_next_req", {63'h0, bus.imem_req}, 64'h1);
    check("t1_next_addr", bus.imem_addr, 64'h4);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.halt;
    end
    check("t1_halt_timeout", {63'h0, seen}, 64'h1);
    check("t1_halt_count", {32'h0, bus.fetch_count}, 64'h3);
    redirect_pulse(64'h40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_halt_sticky", {63'h0, bus.halt}, 64'h1);
      check("t1_halt_req", {63'h0, bus.imem_req}, 64'h0);
      check("t1_halt_valid", {63'h0, bus.instr_valid}, 64'h0);
    end
    queues_empty("t1");

    // Redirect during an outstanding request, then redirect while valid.
    lat = 3;
    exp_req = '{64'h0, 64'h4, 64'h8, 64'h40, 64'h80, 64'h84};
    exp_out.push_back('{64'h0, 32'h00500093});
    exp_out.push_back('{64'h4, 32'h00100113});
    exp_out.push_back('{64'h80, 32'h00500313});
    do_reset();
    bus.instr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.imem_req && (bus.imem_addr == 64'h8);
    end
    check("t2_req8_timeout", {63'h0, seen}, 64'h1);
    @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h40;
    bus.instr_ready = 1'b0;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    @(negedge clk);
    check("t2_addr_held", bus.imem_addr, 64'h8);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus.instr_valid;
    end
    check("t2_valid_timeout", {63'h0, seen}, 64'h1);
    check("t2_redirect_pc", bus.pc, 64'h40);
    check("t2_redirect_instr", {32'h0, bus.instruction}, 64'h00300213);
    check("t2_count_before", {32'h0, bus.fetch_count}, 64'h2);
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h80;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    @(negedge clk);
    check("t2_count_dropped", {32'h0, bus.fetch_count}, 64'h2);
    check("t2_req_80", {63'h0, bus.imem_req}, 64'h1);
    check("t2_addr_80", bus.imem_addr, 64'h80);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.halt;
    end
    check("t2_halt_timeout", {63'h0, seen}, 64'h1);
    check("t2_halt_count", {32'h0, bus.fetch_count}, 64'h3);
    queues_empty("t2");

    // Redirect coincident with ack, then misaligned redirect and reset.
    lat = 1;
    exp_req = '{64'h0, 64'h40, 64'h44};
    exp_out.push_back('{64'h40, 32'h00300213});
    do_reset();
    bus.instr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = bus.imem_ack;
    end
    check("t3_ack_timeout", {63'h0, seen}, 64'h1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h40;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus.imem_req && (bus.imem_addr == 64'h44);
    end
    check("t3_req44_timeout", {63'h0, seen}, 64'h1);
    redirect_pulse(64'h42);
    @(negedge clk);
    check("t3_fault", {63'h0, bus.fault}, 64'h1);
    check("t3_fault_req", {63'h0, bus.imem_req}, 64'h0);
    check("t3_fault_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("t3_fault_count", {32'h0, bus.fetch_count}, 64'h1);
    redirect_pulse(64'h80);
    @(negedge clk);
    check("t3_fault_sticky", {63'h0, bus.fault}, 64'h1);
    check("t3_fault_req2", {63'h0, bus.imem_req}, 64'h0);
    queues_empty("t3");

    exp_req.push_back(64'h0);
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.imem_req;
    end
    check("t3_rereq_timeout", {63'h0, seen}, 64'h1);
    check("t3_rereq_addr", bus.imem_addr, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("t3_final_req_left", exp_req.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
